// File: rtl/pc_stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_stack_pkg                                               |
// | Purpose : Shared command codes and FSM state type for the chip8      |
// |           program-counter / call-stack unit.                         |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pc_stack_pkg;

   // Sequencing command codes issued by the interpreter FSM.
   // Codes 6 and 7 are unassigned and flagged as illegal.
   localparam logic [2:0] CMD_INC    = 3'd0;
   localparam logic [2:0] CMD_SKIP   = 3'd1;
   localparam logic [2:0] CMD_JP     = 3'd2;
   localparam logic [2:0] CMD_CALL   = 3'd3;
   localparam logic [2:0] CMD_RET    = 3'd4;
   localparam logic [2:0] CMD_JP_OFF = 3'd5;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RET  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ram                                                        |
// | Purpose : Simple dual-port RAM, one write port and one synchronous   |
// |           read port with a single cycle of read latency.             |
// | Ports   : clk   - clock                                              |
// |           we    - write enable                                       |
// |           waddr - write address      wdata - write data              |
// |           raddr - read address       q     - read data (registered)  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

   // A write at one edge is visible to a read addressed in the following
   // cycle, which is all the call stack relies on.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      q <= r_mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_stack                                                   |
// | Purpose : chip8 program counter and call stack. Executes advance,    |
// |           skip, jump, jump+offset, call and return commands.         |
// | Ports   : clk, rst         - clock, synchronous active-high reset    |
// |           cmd_v/cmd        - command valid / code                    |
// |           cmd_ready        - command can be accepted this cycle      |
// |           target, offset   - jump/call destination, JP_OFF offset    |
// |           pc, sp           - program counter, stack occupancy        |
// |           ret_done         - pulse when a return has loaded pc       |
// |           err_ovf/unf/ill  - sticky overflow/underflow/illegal flags |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pc_stack
   import pc_stack_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int STACK_AW   = 4,
   parameter int INC_STEP   = 2,
   parameter int RESET_PC   = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_v,
   input  logic [2:0]            cmd,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] target,
   input  logic [7:0]            offset,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [STACK_AW:0]     sp,
   output logic                  ret_done,
   output logic                  err_ovf,
   output logic                  err_unf,
   output logic                  err_ill
);

   // Occupancy value meaning "stack full" (depth = 2**STACK_AW).
   localparam logic [STACK_AW:0] SP_FULL = {1'b1, {STACK_AW{1'b0}}};

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [STACK_AW:0]     r_sp;
   logic                  r_ret_done;
   logic                  r_err_ovf;
   logic                  r_err_unf;
   logic                  r_err_ill;
   logic                  w_accept;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic [STACK_AW-1:0]   w_raddr;
   logic [ADDR_WIDTH-1:0] w_q;

   assign w_accept = cmd_v && cmd_ready;
   assign w_full   = (r_sp == SP_FULL);
   assign w_empty  = (r_sp == '0);
   assign w_push   = w_accept && (cmd == CMD_CALL) && !w_full;
   // Top of stack; driven every cycle so q is ready one edge after a RET.
   assign w_raddr  = r_sp[STACK_AW-1:0] - STACK_AW'(1);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_v && (cmd == CMD_RET) && !w_empty) begin
               w_state_next = ST_RET;
            end
         end
         ST_RET: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------- PC, SP and sticky flags ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= ADDR_WIDTH'(RESET_PC);
         r_sp       <= '0;
         r_ret_done <= 1'b0;
         r_err_ovf  <= 1'b0;
         r_err_unf  <= 1'b0;
         r_err_ill  <= 1'b0;
      end else begin
         r_ret_done <= 1'b0;
         if (r_state == ST_RET) begin
            r_pc       <= w_q;
            r_ret_done <= 1'b1;
         end else if (w_accept) begin
            case (cmd)
               CMD_INC:    r_pc <= r_pc + ADDR_WIDTH'(INC_STEP);
               CMD_SKIP:   r_pc <= r_pc + ADDR_WIDTH'(2 * INC_STEP);
               CMD_JP:     r_pc <= target;
               // Carry out of the top bit is simply dropped.
               CMD_JP_OFF: r_pc <= target + ADDR_WIDTH'(offset);
               CMD_CALL: begin
                  if (w_full) begin
                     r_err_ovf <= 1'b1;
                  end else begin
                     r_sp <= r_sp + 1'b1;
                     r_pc <= target;
                  end
               end
               CMD_RET: begin
                  if (w_empty) begin
                     r_err_unf <= 1'b1;
                  end else begin
                     r_sp <= r_sp - 1'b1;
                  end
               end
               default: r_err_ill <= 1'b1;
            endcase
         end
      end
   end

   // Return-address storage; the pushed value is the current pc.
   ram #(
      .DATA_WIDTH (ADDR_WIDTH),
      .ADDR_WIDTH (STACK_AW)
   ) stack (
      .clk   (clk),
      .we    (w_push),
      .waddr (r_sp[STACK_AW-1:0]),
      .wdata (r_pc),
      .raddr (w_raddr),
      .q     (w_q)
   );

   assign pc       = r_pc;
   assign sp       = r_sp;
   assign ret_done = r_ret_done;
   assign err_ovf  = r_err_ovf;
   assign err_unf  = r_err_unf;
   assign err_ill  = r_err_ill;

endmodule
`default_nettype wire
